// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit:
// operation and state encodings, sizing constants and a sign helper.
package ex_mdu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned MDU_ITER = 32;
  localparam int unsigned CNT_W    = $clog2(MDU_ITER);

  // EX result-mux select value for the multiply/divide result
  localparam logic [3:0] EX_RES_MDU = 4'd6;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } mdu_state_e;

  // Magnitude of a value that is negative when neg is set
  function automatic logic [XLEN-1:0] twos_mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// EX-stage handshake between the pipeline (master) and the MDU (slave).
interface ex_mdu_if;
  import ex_mdu_pkg::*;

  logic            start;
  mdu_op_e         op;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            hold;
  logic            annul;
  logic [XLEN-1:0] result;
  logic            ready;
  logic            stallreq;

  modport master (
    output start, op, opa, opb, hold, annul,
    input  result, ready, stallreq
  );

  modport slave (
    input  start, op, opa, opb, hold, annul,
    output result, ready, stallreq
  );

endinterface

// File: rtl/ex_mdu_div_core.sv
// One restoring-division step on a packed {remainder, quotient} register.
module ex_mdu_div_core
  import ex_mdu_pkg::*;
(
  input  logic [2*XLEN-1:0] rq_i,
  input  logic [XLEN-1:0]   divisor_i,
  output logic [2*XLEN-1:0] rq_o
);

  logic [XLEN:0] rem_ext;
  logic [XLEN:0] diff;
  logic          ge;

  // Shift in the next dividend bit; the trial subtract never exceeds XLEN bits when it succeeds
  always_comb begin
    rem_ext = rq_i[2*XLEN-1:XLEN-1];
    diff    = rem_ext - {1'b0, divisor_i};
    ge      = ~diff[XLEN];
    rq_o    = {(ge ? diff[XLEN-1:0] : rem_ext[XLEN-1:0]), rq_i[XLEN-2:0], ge};
  end

endmodule

// File: rtl/ex_mdu.sv
// Multi-cycle RV32M multiply/divide unit for the EX stage: 32 iterations,
// sign fixup, special-case divides, and a stall request while busy.
module ex_mdu
  import ex_mdu_pkg::*;
(
  input logic     clk,
  input logic     rst,
  ex_mdu_if.slave mdu_io
);

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              ready_q, ready_d;

  logic              in_div, a_sgn, b_sgn, a_neg, b_neg;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   sel, fix_res;

  // Operand decode for the op presented to EX
  always_comb begin
    in_div   = mdu_io.op[2];
    a_sgn    = in_div ? ~mdu_io.op[0] : (mdu_io.op == OP_MULH || mdu_io.op == OP_MULHSU);
    b_sgn    = in_div ? ~mdu_io.op[0] : (mdu_io.op == OP_MULH);
    a_neg    = a_sgn & mdu_io.opa[XLEN-1];
    b_neg    = b_sgn & mdu_io.opb[XLEN-1];
    a_mag    = twos_mag(mdu_io.opa, a_neg);
    b_mag    = twos_mag(mdu_io.opb, b_neg);
    div_zero = in_div && (mdu_io.opb == '0);
    div_ovf  = in_div && ~mdu_io.op[0] && (mdu_io.opa == {1'b1, {(XLEN-1){1'b0}}})
               && (mdu_io.opb == '1);
  end

  // Multiply step: conditional add into the upper half, then shift right
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q & {XLEN{acc_q[0]}}};
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
  end

  ex_mdu_div_core u_div_core (
    .rq_i      (acc_q),
    .divisor_i (opnd_q),
    .rq_o      (div_next)
  );

  // Sign fixup: products negate the full 64 bits before the half is selected
  always_comb begin
    prod_fix = neg_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;
    if (op_q[2]) begin
      sel = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    end else begin
      sel = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
    fix_res = twos_mag(sel, op_q[2] & neg_q);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    result_d = result_q;
    ready_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mdu_io.start) begin
          op_d  = mdu_io.op;
          neg_d = (in_div && mdu_io.op[1]) ? a_neg : (a_neg ^ b_neg);
          cnt_d = '0;
          if (div_zero) begin
            result_d = mdu_io.op[1] ? mdu_io.opa : '1;
            ready_d  = 1'b1;
            state_d  = ST_DONE;
          end else if (div_ovf) begin
            result_d = mdu_io.op[1] ? '0 : mdu_io.opa;
            ready_d  = 1'b1;
            state_d  = ST_DONE;
          end else begin
            acc_d   = {XLEN'(0), (in_div ? a_mag : b_mag)};
            opnd_d  = in_div ? b_mag : a_mag;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MDU_ITER - 1)) begin
          state_d = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        result_d = fix_res;
        ready_d  = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        // Result stays presented until the pipeline advances
        if (mdu_io.hold) begin
          ready_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (mdu_io.annul) begin
      state_d = ST_IDLE;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign mdu_io.result   = result_q;
  assign mdu_io.ready    = ready_q;
  assign mdu_io.stallreq = (state_q != ST_DONE) && mdu_io.start && !mdu_io.annul;

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: directed M-ops push expected results,
// a negedge monitor checks result, latency, stall count and ready length.
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  logic clk;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t;
    int          len;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  exp_t mon_e;
  logic rdy_prev  = 1'b0;
  int   stall_cnt = 0;
  int   run_len   = 0;

  ex_mdu_if mdu();

  ex_mdu dut (
    .clk    (clk),
    .rst    (rst),
    .mdu_io (mdu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: pops on each new ready, then tracks stability and duration
  always @(negedge clk) begin
    if (rst) begin
      rdy_prev  = 1'b0;
      stall_cnt = 0;
    end else begin
      if (mdu.ready && !rdy_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready got ready=1 result=%h required ready=0 (cycle %0d)",
                   mdu.result, cyc);
          cur.len = 1;
          cur.res = mdu.result;
          cur.id  = -1;
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("result_%0d", mon_e.id), mdu.result, mon_e.res);
          check($sformatf("latency_%0d", mon_e.id), 32'(cyc - mon_e.t), 32'(mon_e.lat));
          check($sformatf("stalls_%0d", mon_e.id), 32'(stall_cnt), 32'(mon_e.lat));
          cur = mon_e;
        end
        run_len   = 1;
        stall_cnt = 0;
      end else if (mdu.ready) begin
        run_len++;
        check($sformatf("stable_%0d", cur.id), mdu.result, cur.res);
      end else if (rdy_prev) begin
        check($sformatf("ready_len_%0d", cur.id), 32'(run_len), 32'(cur.len));
      end
      if (sb.size() > 0 && cyc >= sb[0].t && mdu.stallreq) stall_cnt++;
      rdy_prev = mdu.ready;
    end
  end

  // Issue one M-op (called just after a posedge) and retire it through DONE
  task automatic issue(input int id, input mdu_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input int lat, input int hold_n);
    exp_t e;
    int   n;
    e.res = exp; e.lat = lat; e.t = cyc; e.len = hold_n + 1; e.id = id;
    sb.push_back(e);
    mdu.start = 1'b1; mdu.op = op; mdu.opa = a; mdu.opb = b; mdu.hold = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!mdu.ready && n < 100);
    if (!mdu.ready) begin
      checks++;
      errors++;
      $display("FAIL timeout_%0d got ready=0 required ready=1 within 100 cycles", id);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
    mdu.hold = (hold_n > 0);
    repeat (hold_n) begin
      @(posedge clk); #1;
    end
    mdu.hold = 1'b0;
    @(posedge clk); #1;
    mdu.start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mdu.start = 1'b0; mdu.op = OP_MUL; mdu.opa = '0; mdu.opb = '0;
    mdu.hold = 1'b0; mdu.annul = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_result", mdu.result, 32'h0);
    check("reset_ready", 32'(mdu.ready), 32'h0);
    check("reset_stallreq", 32'(mdu.stallreq), 32'h0);
    @(posedge clk); #1;

    issue( 1, OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0);
    issue( 2, OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, 0);
    issue( 3, OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0);
    issue( 4, OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
    issue( 5, OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, 0);
    issue( 6, OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34, 0);
    issue( 7, OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34, 0);
    issue( 8, OP_DIVU,   32'd100,      32'd7,        32'd14,       34, 0);
    issue( 9, OP_REMU,   32'd100,      32'd7,        32'd2,        34, 0);
    issue(10, OP_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34, 0);
    issue(11, OP_REM,    32'd100,      32'hFFFFFFF9, 32'd2,        34, 0);
    issue(12, OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF,  1, 0);
    issue(13, OP_REM,    32'd5,        32'd0,        32'd5,         1, 0);
    issue(14, OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF,  1, 0);
    issue(15, OP_REMU,   32'd5,        32'd0,        32'd5,         1, 0);
    issue(16, OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1, 0);
    issue(17, OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000,  1, 0);
    issue(18, OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, 0);

    // Annul ten cycles into a multiply; nothing is expected from it
    mdu.start = 1'b1; mdu.op = OP_MUL; mdu.opa = 32'd11; mdu.opb = 32'd13;
    repeat (10) begin
      @(posedge clk); #1;
    end
    mdu.annul = 1'b1;
    @(negedge clk);
    check("annul_stallreq", 32'(mdu.stallreq), 32'h0);
    @(posedge clk); #1;
    mdu.annul = 1'b0;
    mdu.start = 1'b0;
    @(negedge clk);
    check("annul_ready", 32'(mdu.ready), 32'h0);
    @(posedge clk); #1;
    issue(19, OP_MUL,    32'h12345678, 32'd9,        32'hA3D70A38, 34, 0);

    // Downstream hold keeps the result presented, then a back-to-back multiply
    issue(20, OP_DIVU,   32'd100,      32'd7,        32'd14,       34, 5);
    issue(21, OP_MUL,    32'd7,        32'd6,        32'd42,       34, 0);

    // Reset in the middle of a multiply
    mdu.start = 1'b1; mdu.op = OP_MULHU; mdu.opa = 32'hDEADBEEF; mdu.opb = 32'h1234;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    mdu.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_result", mdu.result, 32'h0);
    check("midrst_ready", 32'(mdu.ready), 32'h0);
    @(posedge clk); #1;
    issue(22, OP_MUL,    32'd3,        32'd5,        32'd15,       34, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
# ex_mdu

Multi-cycle RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It takes the M-extension operation and the two source operands presented to EX, iterates over 32 cycles, and returns the 32-bit result to the EX result mux. While it is busy, it raises a stall request to the pipeline controller so that ID/EX and earlier stages hold their contents.

## Interface
- XLEN, default 32, operand/result width; only 32 supported
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  EX holds a valid M-op (decoded from ex_aluop M group)
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- opa  in  XLEN  rs1 value (ex_reg1)
- opb  in  XLEN  rs2 value (ex_reg2)
- hold  in  1  downstream stall (stall[4]); EX output must stay put
- annul  in  1  abort current operation (flush)
- result  out  XLEN  operation result, valid while ready=1
- ready  out  1  result valid
- stallreq  out  1  stall request to ctrl, combinational

## Operation
- States are IDLE, CALC, FIXUP, DONE. Reset puts the unit in IDLE with result=0, ready=0, stallreq=0, and the counter at 0.
- IDLE, start=1: latch op and the operand magnitudes. Signed operand = DIV/REM both, MULH both, MULHSU opa only. Record the result sign. Counter=0, then go to CALC.
- IDLE, start=1, special divide: the operation goes directly to DONE with no CALC.
  - divisor=0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give opa.
  - DIV/REM with opa=0x80000000 and opb=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- CALC: one iteration per cycle; the counter increments and the unit leaves at count 31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring, 1 quotient bit per cycle, 64-bit remainder/quotient register.
- FIXUP: apply two's-complement negation if the sign is set.
  - Multiply: negate the 64-bit product. MUL selects low 32 bits; MULH* selects high 32.
  - Divide: quotient sign = opa sign xor opb sign; remainder sign = opa sign.
  - Register result, go to DONE.
- DONE: ready=1. Stay while hold=1; go to IDLE when hold=0.
- stallreq = (state≠DONE) and start and not annul. It is therefore high in the start cycle and through FIXUP, and low in DONE.
- annul has priority over everything except rst. Any state goes to IDLE next cycle with ready=0. stallreq=0 in the annul cycle.
- start falling to 0 mid-CALC never occurs (ID/EX is held by our stallreq). If it does, the operation completes anyway, but its result is not consumed.
- The unit does not restart on the same instruction: DONE exits only when the pipeline advances (hold=0), after which start reflects the next instruction.

## Timing
- Normal op, start sampled at cycle T:
  - CALC runs T+1..T+32.
  - FIXUP is at T+33.
  - ready=1 at T+34.
  - stallreq=1 for cycles T..T+33, i.e. 34 stall cycles; the instruction leaves EX at the edge ending T+34.
- Special divide: ready=1 at T+1, 1 stall cycle.
- Back-to-back M-ops: DONE→IDLE costs no extra cycle. The next start is seen in IDLE the cycle after the pipeline advances.
- rst mid-operation: IDLE next edge, all outputs at reset values.

## Structure
- Shared package (defines.vh) additions:
  - MDU funct3 encodings.
  - EX_RES_MDU alusel value.
  - MDU state encodings.
  - Iteration count constant 32.
- One sub-module, mdu_div_core: restoring divide iteration, combinational, one step. ex_mdu instantiates it.
- ex_mdu owns the FSM, the multiply accumulator, sign fixup, and special cases.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → result 0xFFFFFFEB; ready at T+34; stallreq high for exactly 34 cycles.
- MULH / MULHSU / MULHU with opa=0xFFFFFFFF, opb=0xFFFFFFFF → 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV and REM by 0 with opa=5 → 0xFFFFFFFF and 5, ready at T+1. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- annul at T+10 → IDLE at T+11, ready never asserted, stallreq low from T+10. A new start at T+12 completes normally.
- hold=1 for 5 cycles after DONE → ready stays 1 and result stays stable, no restart. Hold release followed by the next MUL start → second result is correct.
